// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Iterative radix-4 Booth multiplier-accumulator. One Booth digit (two
//   multiplier bits) is retired per clock, so an operation takes
//   N = A_W/2 + 1 cycles from the accepting edge to the result edge.
//   Operands are signed or unsigned per operation; an optional preset is
//   added to the product. The result is (a*b + acc_in) mod 2^P_W.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset (clears every register)
//   start     request, sampled only while idle
//   is_signed 1: a, b are two's complement, 0: unsigned (latched at start)
//   acc_en    1: add acc_in to the product (latched at start)
//   a         multiplier, A_W bits (latched at start)
//   b         multiplicand, B_W bits (latched at start)
//   acc_in    accumulate preset, P_W bits (latched at start)
//   busy      high while an operation is in progress (registered)
//   p_valid   one-cycle pulse when p carries a new result
//   p         result, held until the next completion
module booth_mult_seq #(
  parameter int A_W = 12,
  parameter int B_W = 12,
  parameter int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic           acc_en,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [P_W-1:0] acc_in,
  output logic           busy,
  output logic           p_valid,
  output logic [P_W-1:0] p
);

  localparam int N     = A_W / 2 + 1;
  localparam int CNT_W = $clog2(N);
  // Multiplier shift register: A_W+2 extended bits plus the implicit a[-1].
  localparam int AS_W  = A_W + 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AS_W-1:0]        a_sh_q, a_sh_d;
  logic signed [B_W:0]    b_q, b_d;
  logic signed [P_W-1:0]  acc_q, acc_d;
  logic [P_W-1:0]         p_q, p_d;
  logic                   p_valid_q, p_valid_d;

  logic signed [P_W-1:0]  pp;
  logic signed [P_W-1:0]  pp_sh;
  logic signed [P_W-1:0]  acc_next;

  // Partial product d*b for one Booth window, sign-extended to P_W.
  // Negation is ~b+1 on the extended multiplicand; doubling is a left shift.
  function automatic logic signed [P_W-1:0] booth_pp(
    input logic [2:0]          win,
    input logic signed [B_W:0] bx
  );
    logic signed [P_W-1:0] b_w;
    logic signed [P_W-1:0] b_neg;
    b_w   = {{(P_W-B_W-1){bx[B_W]}}, bx};
    b_neg = ~b_w + P_W'(1);
    case (win)
      3'b001, 3'b010: booth_pp = b_w;
      3'b011:         booth_pp = b_w <<< 1;
      3'b100:         booth_pp = b_neg <<< 1;
      3'b101, 3'b110: booth_pp = b_neg;
      default:        booth_pp = '0;
    endcase
  endfunction

  // The shift register is moved two bits per iteration, so the current
  // window {a[2i+1], a[2i], a[2i-1]} is always in its three low bits.
  always_comb begin
    pp       = booth_pp(a_sh_q[2:0], b_q);
    pp_sh    = pp << {cnt_q, 1'b0};
    acc_next = acc_q + pp_sh;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_d       = b_q;
    acc_d     = acc_q;
    p_d       = p_q;
    p_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          b_d     = {is_signed & b[B_W-1], b};
          a_sh_d  = {{2{is_signed & a[A_W-1]}}, a, 1'b0};
          acc_d   = acc_en ? acc_in : '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: begin
        acc_d  = acc_next;
        a_sh_d = a_sh_q >> 2;
        if (cnt_q == CNT_LAST) begin
          p_d       = acc_next;
          p_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Register stage: every flop, data included, is cleared by reset so an
  // aborted operation leaves no trace on p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      p_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign p_valid = p_valid_q;
  assign p       = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq: three instances (12x12, 4x2, 16x18), a
// cycle-level reference model compared every cycle, and directed vectors
// with hand-computed results on the 12x12 instance.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        d_start [3];
  logic        d_sgn   [3];
  logic        d_ae    [3];
  logic [63:0] d_a     [3];
  logic [63:0] d_b     [3];
  logic [63:0] d_acc   [3];

  logic        busy0, busy1, busy2, pv0, pv1, pv2;
  logic [23:0] p0;
  logic [5:0]  p1;
  logic [33:0] p2;

  logic        busy_o [3];
  logic        pv_o   [3];
  logic [63:0] p_o    [3];

  assign busy_o[0] = busy0;
  assign busy_o[1] = busy1;
  assign busy_o[2] = busy2;
  assign pv_o[0]   = pv0;
  assign pv_o[1]   = pv1;
  assign pv_o[2]   = pv2;
  assign p_o[0]    = {40'd0, p0};
  assign p_o[1]    = {58'd0, p1};
  assign p_o[2]    = {30'd0, p2};

  booth_mult_seq #(.A_W(12), .B_W(12)) u0 (
    .clk(clk), .rst(rst), .start(d_start[0]), .is_signed(d_sgn[0]),
    .acc_en(d_ae[0]), .a(d_a[0][11:0]), .b(d_b[0][11:0]),
    .acc_in(d_acc[0][23:0]), .busy(busy0), .p_valid(pv0), .p(p0));

  booth_mult_seq #(.A_W(4), .B_W(2)) u1 (
    .clk(clk), .rst(rst), .start(d_start[1]), .is_signed(d_sgn[1]),
    .acc_en(d_ae[1]), .a(d_a[1][3:0]), .b(d_b[1][1:0]),
    .acc_in(d_acc[1][5:0]), .busy(busy1), .p_valid(pv1), .p(p1));

  booth_mult_seq #(.A_W(16), .B_W(18)) u2 (
    .clk(clk), .rst(rst), .start(d_start[2]), .is_signed(d_sgn[2]),
    .acc_en(d_ae[2]), .a(d_a[2][15:0]), .b(d_b[2][17:0]),
    .acc_in(d_acc[2][33:0]), .busy(busy2), .p_valid(pv2), .p(p2));

  int checks = 0;
  int errors = 0;

  function automatic int aw_of(int k);
    case (k)
      0:       return 12;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int bw_of(int k);
    case (k)
      0:       return 12;
      1:       return 2;
      default: return 18;
    endcase
  endfunction

  // Plain integer arithmetic: interpret operands, multiply, add, wrap.
  function automatic logic [63:0] ref_mac(int aw, int bw, logic sgn, logic ae,
                                          logic [63:0] a, logic [63:0] b,
                                          logic [63:0] acc);
    longint      av, bv, r;
    logic [63:0] am, bm, ru;
    am = a & ((64'd1 << aw) - 64'd1);
    bm = b & ((64'd1 << bw) - 64'd1);
    av = longint'(am);
    bv = longint'(bm);
    if (sgn && am[aw-1]) av = av - (longint'(1) << aw);
    if (sgn && bm[bw-1]) bv = bv - (longint'(1) << bw);
    r = av * bv;
    if (ae) r = r + longint'(acc);
    ru = r;
    return ru & ((64'd1 << (aw + bw)) - 64'd1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state per instance: an operation is in flight for
  // N cycles after acceptance, then the result appears with a one-cycle pulse.
  logic        m_fl   [3];
  int          m_rem  [3];
  logic [63:0] m_pend [3];
  logic [63:0] m_p    [3];
  logic        m_pv   [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_fl[k] = 1'b0; m_rem[k] = 0; m_pend[k] = '0; m_p[k] = '0; m_pv[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          m_fl[k] = 1'b0; m_pv[k] = 1'b0; m_p[k] = '0;
        end else begin
          m_pv[k] = 1'b0;
          if (m_fl[k]) begin
            m_rem[k] = m_rem[k] - 1;
            if (m_rem[k] == 0) begin
              m_fl[k] = 1'b0;
              m_pv[k] = 1'b1;
              m_p[k]  = m_pend[k];
            end
          end else if (d_start[k]) begin
            m_fl[k]   = 1'b1;
            m_rem[k]  = aw_of(k) / 2 + 1;
            m_pend[k] = ref_mac(aw_of(k), bw_of(k), d_sgn[k], d_ae[k],
                                d_a[k], d_b[k], d_acc[k]);
          end
        end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy[%0d]", k), 64'(busy_o[k]), 64'(m_fl[k]));
        chk($sformatf("p_valid[%0d]", k), 64'(pv_o[k]), 64'(m_pv[k]));
        chk($sformatf("p[%0d]", k), p_o[k], m_p[k]);
      end
    end
  end

  task automatic wait_pv(input int k, output int nbusy);
    int t;
    t = 0;
    nbusy = 0;
    while (!pv_o[k] && t < 40) begin
      if (busy_o[k]) nbusy++;
      t++;
      @(negedge clk);
    end
    chk($sformatf("pv_seen[%0d]", k), 64'(pv_o[k]), 64'd1);
  endtask

  task automatic issue(input int k, input logic sgn, input logic ae,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] acc,
                       output logic [63:0] p, output int nbusy);
    @(negedge clk);
    d_sgn[k] = sgn; d_ae[k] = ae; d_a[k] = a; d_b[k] = b; d_acc[k] = acc;
    d_start[k] = 1'b1;
    @(negedge clk);
    d_start[k] = 1'b0;
    wait_pv(k, nbusy);
    p = p_o[k];
  endtask

  task automatic run_rand(input int k, input int n);
    logic [63:0] pr, ra, rb, rc;
    int          nb;
    for (int i = 0; i < n; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = '1;
      if ($urandom_range(0, 3) == 0) rb = 64'd1 << (bw_of(k) - 1);
      issue(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, rc, pr, nb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pr;
    int          nb, gap;
    for (int k = 0; k < 3; k++) begin
      d_start[k] = 1'b0; d_sgn[k] = 1'b0; d_ae[k] = 1'b0;
      d_a[k] = '0; d_b[k] = '0; d_acc[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy0), 64'd0);
    chk("reset_pv", 64'(pv0), 64'd0);
    chk("reset_p", p_o[0], 64'd0);
    rst = 1'b0;

    chk("model_pin_signed", ref_mac(12, 12, 1'b1, 1'b0, 64'hFFD, 64'h5, 64'd0), 64'hFFFFF1);
    chk("model_pin_acc", ref_mac(12, 12, 1'b1, 1'b1, 64'd1, 64'd1, 64'h7FFFFF), 64'h800000);

    issue(0, 1'b1, 1'b0, 64'hFFD, 64'h005, 64'd0, pr, nb);
    chk("signed_basic", pr, 64'hFFFFF1);
    chk("signed_basic_busy_cycles", 64'(nb), 64'd7);

    // Abort mid-operation: p was nonzero and must clear, no pulse follows.
    @(negedge clk);
    d_sgn[0] = 1'b0; d_ae[0] = 1'b0; d_a[0] = 64'd5; d_b[0] = 64'd5;
    d_start[0] = 1'b1;
    @(negedge clk);
    d_start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_p", p_o[0], 64'd0);
    chk("abort_pv", 64'(pv0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(0, 1'b0, 1'b0, 64'd5, 64'd5, 64'd0, pr, nb);
    chk("after_abort", pr, 64'h000019);

    issue(0, 1'b1, 1'b0, 64'h800, 64'h800, 64'd0, pr, nb);
    chk("signed_min_min", pr, 64'h400000);
    issue(0, 1'b1, 1'b0, 64'h7FF, 64'h800, 64'd0, pr, nb);
    chk("signed_max_min", pr, 64'hC00800);
    issue(0, 1'b0, 1'b0, 64'hFFF, 64'hFFF, 64'd0, pr, nb);
    chk("unsigned_max_max", pr, 64'hFFE001);
    issue(0, 1'b0, 1'b0, 64'hFFF, 64'h001, 64'd0, pr, nb);
    chk("unsigned_max_one", pr, 64'h000FFF);
    issue(0, 1'b1, 1'b1, 64'd2, 64'd3, 64'h000064, pr, nb);
    chk("acc_basic", pr, 64'h00006A);
    issue(0, 1'b1, 1'b1, 64'd1, 64'd1, 64'h7FFFFF, pr, nb);
    chk("acc_wrap", pr, 64'h800000);

    // Start pulsed while busy with other operands must be ignored.
    @(negedge clk);
    d_sgn[0] = 1'b0; d_ae[0] = 1'b0; d_a[0] = 64'd2; d_b[0] = 64'd3;
    d_start[0] = 1'b1;
    @(negedge clk);
    d_start[0] = 1'b0;
    repeat (2) @(negedge clk);
    d_a[0] = 64'd7; d_b[0] = 64'd7; d_start[0] = 1'b1;
    @(negedge clk);
    d_start[0] = 1'b0;
    wait_pv(0, nb);
    chk("ignore_while_busy", p_o[0], 64'h000006);
    repeat (10) @(negedge clk);
    chk("ignore_no_second_op", 64'(busy0), 64'd0);

    // Start held high across completion: second op begins right after p_valid.
    @(negedge clk);
    d_sgn[0] = 1'b1; d_ae[0] = 1'b0; d_a[0] = 64'd3; d_b[0] = 64'd4;
    d_start[0] = 1'b1;
    @(negedge clk);
    d_a[0] = 64'hFFF; d_b[0] = 64'h002;
    wait_pv(0, nb);
    chk("held_first", p_o[0], 64'h00000C);
    @(negedge clk);
    d_start[0] = 1'b0;
    gap = 1;
    while (!pv0 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    chk("held_second", p_o[0], 64'hFFFFFE);
    chk("held_gap", 64'(gap), 64'd8);

    issue(1, 1'b1, 1'b0, 64'h8, 64'h2, 64'd0, pr, nb);
    chk("narrow_signed_min", pr, 64'h10);
    issue(2, 1'b0, 1'b0, 64'hFFFF, 64'h3FFFF, 64'd0, pr, nb);
    chk("wide_unsigned_max", pr, 64'h3_FFFB_0001);

    fork
      run_rand(0, 40);
      run_rand(1, 80);
      run_rand(2, 40);
    join
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
